eis_unit: RTL and testbench
===========================

# eis_unit

Parametrised multi-cycle extended-arithmetic unit for the PDP-11 datapath. It executes the EIS instructions MUL, DIV, ASH and ASHC iteratively, one bit per cycle, and sits beside the single-cycle ALU. Operands come from the register file. Results and N/Z/V/C are returned through a start/done handshake so the control FSM can stall while the unit is busy.

## Interface
Parameters:
- WIDTH, 16: register width; MUL products and DIV/ASHC operands are 2*WIDTH.
- CNT_W, $clog2(2*WIDTH)+1: signed shift-count field width, taken from a[CNT_W-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  0=MUL, 1=DIV, 2=ASH, 3=ASHC; latched at start.
- a  in  WIDTH  source operand: multiplier, divisor, or shift count. Latched at start.
- hi  in  WIDTH  destination high word (Rn); latched at start.
- lo  in  WIDTH  destination low word (Rn|1); MUL multiplicand and ASH operand. Latched at start.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse in DONE.
- res_hi  out  WIDTH  result high word; held until the next accepted start.
- res_lo  out  WIDTH  result low word; held likewise.
- flags  out  4  {N,Z,V,C}, matching the ps[3:0] layout; held likewise.

## Operation
- **MUL**: signed a × lo gives a 2W product in {res_hi,res_lo}.
  - N = product sign; Z = (product == 0); V = 0.
  - C = 1 when the product is outside [-2^(W-1), 2^(W-1)-1].
- **DIV**: signed {hi,lo} ÷ a.
  - res_hi = quotient, truncated toward zero; res_lo = remainder, which takes the dividend's sign.
  - N and Z are taken from the quotient; V = C = 0.
  - Divisor 0: V = 1, C = 1, N = 0, Z = 0. res_hi/res_lo = hi/lo unchanged; RUN is skipped.
  - Quotient overflow (does not fit in W signed bits, including -2^(2W-1) ÷ -1): V = 1, C = 0, N = Z = 0, results = hi/lo unchanged.
- **ASH**: shifts lo by signed count a[CNT_W-1:0]; positive is left, negative is arithmetic right.
  - res_lo = result; res_hi = hi unchanged.
  - C = last bit shifted out (0 when count is 0).
  - V = 1 if the sign bit changed at any step.
  - N and Z are taken from the result.
- **ASHC**: same rules as ASH, applied to the 2W value {hi,lo}.
- Datapath arithmetic: MUL uses a sign-magnitude shift-add over W iterations. DIV uses non-restoring division on magnitudes with a sign fix in FIX. All intermediate sums are W+1 bits.
- State machine:
  - IDLE: start → RUN. For DIV with a = 0, start → FIX instead.
  - RUN: iteration counter decrements; at counter == 0 → FIX.
  - FIX: sign correction, overflow check, flag computation, output registers load → DONE.
  - DONE: done = 1; start → RUN or FIX as from IDLE; otherwise → IDLE.
- Shift iteration count = |count|. Count 0 goes from IDLE straight to FIX.
- Reset values: state = IDLE, busy = 0, done = 0, res_hi = res_lo = 0, flags = 0.

## Timing
- Edge 0 is the edge that samples start.
- done is high in the cycle after the following edge:
  - MUL: edge W+1 (W RUN cycles + FIX).
  - DIV: edge W+1.
  - DIV by zero: edge 1.
  - ASH/ASHC: edge |count|+1; count 0 gives edge 1.
- Outputs change only on the FIX→DONE edge and are stable from the DONE cycle onward.
- start while busy = 1 is ignored; no queueing and no error.
- start in the DONE cycle is accepted, allowing back-to-back operations with no idle gap.
- Inputs are don't-care after edge 0.
- reset mid-operation: all registers return to reset values on that edge, and done is not asserted for the aborted operation.
- reset has priority over start.

## Structure
- Op encodings (EIS_MUL, EIS_DIV, EIS_ASH, EIS_ASHC) go in the shared opcode include, next to the existing instruction constants.
- Flag bit positions N=3, Z=2, V=1, C=0 are shared constants in the same include.
- One sub-module: eis_addsub, a W+1-bit add/subtract used by both the MUL and DIV iterations.
- Everything else stays in eis_unit.

## Test plan
All scenarios use WIDTH = 16.
- **MUL, negative product**: a = 0xFFFD, lo = 0x0007 → res = 0xFFFF/0xFFEB, flags = 1000. done at edge 17.
- **MUL, out of 16-bit range**: a = 0x0100, lo = 0x0100 → res = 0x0001/0x0000, flags = 0001.
- **DIV, signed**: hi/lo = 0x0000/0x0064, a = 0xFFF9 → res_hi = 0xFFF2, res_lo = 0x0002, flags = 1000.
- **DIV by zero**: a = 0 → res = hi/lo unchanged, flags = 0011, done at edge 1.
- **DIV overflow**: hi/lo = 0x0001/0x0000, a = 0x0001 → flags = 0010, res unchanged.
- **ASHC**: {0x4000,0x0001} with count +1 → 0x8000/0x0002, flags = 1010, done at edge 2.
  - {0x0000,0x0003} with count -1 (a = 0x003F) → 0x0000/0x0001, flags = 0001.
- **ASH count 0**: lo = 0 → flags = 0100, done at edge 1.
- **Handshake and reset**:
  - start during RUN is ignored.
  - start in the DONE cycle starts the next op, with busy high the following cycle.
  - reset at MUL edge 5 → busy = done = 0 and outputs 0 on the next cycle; a following MUL completes correctly.

Source files
------------

// File: rtl/eis_unit_pkg.sv
// Shared EIS opcode encodings, condition-code bit positions and unit state type.
package eis_unit_pkg;

  typedef enum logic [1:0] {
    EIS_MUL  = 2'd0,
    EIS_DIV  = 2'd1,
    EIS_ASH  = 2'd2,
    EIS_ASHC = 2'd3
  } eis_op_t;

  // Bit positions inside the {N,Z,V,C} nibble (ps[3:0] layout)
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } eis_state_t;

endpackage

// File: rtl/eis_addsub.sv
// W+1-bit add/subtract shared by the MUL shift-add and DIV non-restoring steps.
module eis_addsub #(
  parameter int unsigned W = 16
) (
  input  logic [W:0] x,
  input  logic [W:0] y,
  input  logic       sub,
  output logic [W:0] sum_c
);

  always_comb sum_c = sub ? (x - y) : (x + y);

endmodule

// File: rtl/eis_unit.sv
// Iterative PDP-11 EIS unit: MUL, DIV, ASH, ASHC, one bit per cycle,
// with a start/done handshake and registered results and flags.
module eis_unit
  import eis_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(2*WIDTH)+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [3:0]       flags
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned W2 = 2*WIDTH;
  localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

  eis_state_t       state, state_nx;
  eis_op_t          op_e, op_q;
  logic [W-1:0]     hi_q, lo_q, dv, mq;
  logic [W:0]       pr;
  logic [W2-1:0]    sh;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, ovf_q, left_q, c_q, v_q;

  logic [CNT_W-1:0] cnt_in, cnt_mag;
  logic [W-1:0]     a_mag, lo_mag;
  logic [W2-1:0]    dvd_mag;
  logic             go, skip_run;

  logic [W:0]       as_x, as_y, as_s, mul_sum;
  logic             as_sub, sh_msb, sh_nxt;

  logic [W2-1:0]    prod_mag, prod;
  logic [W-1:0]     rem_mag, quo, rem, fix_hi, fix_lo;
  logic             div_ovf;
  logic [3:0]       fix_fl;

  // Operand magnitudes and start decode taken straight from the inputs
  always_comb begin
    op_e     = eis_op_t'(op);
    cnt_in   = a[CNT_W-1:0];
    cnt_mag  = cnt_in[CNT_W-1] ? CNT_W'(-cnt_in) : cnt_in;
    a_mag    = a[W-1]  ? W'(-a)  : a;
    lo_mag   = lo[W-1] ? W'(-lo) : lo;
    dvd_mag  = hi[W-1] ? W2'(-{hi, lo}) : {hi, lo};
    go       = start && (state == S_IDLE || state == S_DONE);
    skip_run = (op_e == EIS_DIV && a == '0) ||
               ((op_e == EIS_ASH || op_e == EIS_ASHC) && cnt_in == '0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: state_nx = go ? (skip_run ? S_FIX : S_RUN) : S_IDLE;
      S_RUN:          if (cnt == '0) state_nx = S_FIX;
      S_FIX:          state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_RUN) || (state_nx == S_FIX);
      done  <= (state_nx == S_DONE);
    end
  end

  // Adder operands: DIV shifts the partial remainder in, FIX restores a negative remainder
  always_comb begin
    as_x   = {1'b0, pr[W-1:0]};
    as_y   = {1'b0, dv};
    as_sub = 1'b0;
    if (op_q == EIS_DIV) begin
      if (state == S_RUN) begin
        as_x   = {pr[W-1:0], mq[W-1]};
        as_sub = ~pr[W];
      end else begin
        as_x = pr;
      end
    end
    mul_sum = mq[0] ? as_s : {1'b0, pr[W-1:0]};
    sh_msb  = (op_q == EIS_ASHC) ? sh[W2-1] : sh[W-1];
    sh_nxt  = (op_q == EIS_ASHC) ? sh[W2-2] : sh[W-2];
  end

  eis_addsub #(.W(W)) u_addsub (
    .x     (as_x),
    .y     (as_y),
    .sub   (as_sub),
    .sum_c (as_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= EIS_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      dv     <= '0;
      mq     <= '0;
      pr     <= '0;
      sh     <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      left_q <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
    end else if (go) begin
      op_q   <= op_e;
      hi_q   <= hi;
      lo_q   <= lo;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      left_q <= ~cnt_in[CNT_W-1];
      ovf_q  <= dvd_mag[W2-1:W] >= a_mag;
      sh     <= (op_e == EIS_ASHC) ? {hi, lo} : {{W{lo[W-1]}}, lo};
      case (op_e)
        EIS_MUL: begin
          pr    <= '0;
          mq    <= a_mag;
          dv    <= lo_mag;
          neg_q <= a[W-1] ^ lo[W-1];
          cnt   <= CNT_W'(W-1);
        end
        EIS_DIV: begin
          pr    <= {1'b0, dvd_mag[W2-1:W]};
          mq    <= dvd_mag[W-1:0];
          dv    <= a_mag;
          neg_q <= hi[W-1] ^ a[W-1];
          cnt   <= CNT_W'(W-1);
        end
        default: cnt <= cnt_mag - CNT_W'(1);
      endcase
    end else if (state == S_RUN) begin
      cnt <= cnt - CNT_W'(1);
      case (op_q)
        EIS_MUL: begin
          pr <= {1'b0, mul_sum[W:1]};
          mq <= {mul_sum[0], mq[W-1:1]};
        end
        EIS_DIV: begin
          pr <= as_s;
          mq <= {mq[W-2:0], ~as_s[W]};
        end
        default: begin
          if (left_q) begin
            c_q <= sh_msb;
            v_q <= v_q | (sh_msb ^ sh_nxt);
            sh  <= sh << 1;
          end else begin
            c_q <= sh[0];
            sh  <= {sh[W2-1], sh[W2-1:1]};
          end
        end
      endcase
    end
  end

  // Sign fix-up, overflow checks and condition codes, all settled during FIX
  always_comb begin
    prod_mag = {pr[W-1:0], mq};
    prod     = neg_q ? W2'(-prod_mag) : prod_mag;
    rem_mag  = pr[W] ? as_s[W-1:0] : pr[W-1:0];
    quo      = neg_q ? W'(-mq) : mq;
    rem      = hi_q[W-1] ? W'(-rem_mag) : rem_mag;
    div_ovf  = ovf_q || (neg_q ? (mq > MIN_MAG) : mq[W-1]);
    fix_hi   = hi_q;
    fix_lo   = lo_q;
    fix_fl   = '0;
    case (op_q)
      EIS_MUL: begin
        fix_hi         = prod[W2-1:W];
        fix_lo         = prod[W-1:0];
        fix_fl[FLAG_N] = prod[W2-1];
        fix_fl[FLAG_Z] = (prod == '0);
        fix_fl[FLAG_C] = ~((&prod[W2-1:W-1]) | ~(|prod[W2-1:W-1]));
      end
      EIS_DIV: begin
        if (dv == '0) begin
          fix_fl[FLAG_V] = 1'b1;
          fix_fl[FLAG_C] = 1'b1;
        end else if (div_ovf) begin
          fix_fl[FLAG_V] = 1'b1;
        end else begin
          fix_hi         = quo;
          fix_lo         = rem;
          fix_fl[FLAG_N] = quo[W-1];
          fix_fl[FLAG_Z] = (quo == '0);
        end
      end
      EIS_ASH: begin
        fix_lo         = sh[W-1:0];
        fix_fl[FLAG_N] = sh[W-1];
        fix_fl[FLAG_Z] = (sh[W-1:0] == '0);
        fix_fl[FLAG_V] = v_q;
        fix_fl[FLAG_C] = c_q;
      end
      default: begin
        fix_hi         = sh[W2-1:W];
        fix_lo         = sh[W-1:0];
        fix_fl[FLAG_N] = sh[W2-1];
        fix_fl[FLAG_Z] = (sh == '0);
        fix_fl[FLAG_V] = v_q;
        fix_fl[FLAG_C] = c_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_hi <= '0;
      res_lo <= '0;
      flags  <= '0;
    end else if (state == S_FIX) begin
      res_hi <= fix_hi;
      res_lo <= fix_lo;
      flags  <= fix_fl;
    end
  end

endmodule

// File: tb/tb_eis_unit.sv
// Scoreboard bench for eis_unit: arithmetic reference model feeds an expected queue,
// a monitor checks every done pulse against it.
module tb_eis_unit;
  import eis_unit_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, hi = '0, lo = '0;
  logic         busy, done;
  logic [W-1:0] res_hi, res_lo;
  logic [3:0]   flags;

  eis_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rh;
    logic [15:0] rl;
    logic [3:0]  fl;
    int          lat;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic longint wrap(input longint v, input int nb);
    longint md;
    md = longint'(1) << nb;
    v  = v & (md - 1);
    if (v >= md / 2) v = v - md;
    return v;
  endfunction

  // Reference: plain signed arithmetic and value-level shifting
  function automatic exp_t model(input logic [1:0] o, input logic [15:0] ia, ih, il);
    exp_t        e;
    longint      p, dvd, d, q, r, x, nx;
    int          n, nb, mag;
    logic        c, v;
    logic [63:0] bits;
    e.rh = ih; e.rl = il; e.fl = 4'b0000; e.lat = 17; e.at = 0;
    case (o)
      2'd0: begin
        p    = longint'($signed(ia)) * longint'($signed(il));
        bits = p;
        e.rh = bits[31:16];
        e.rl = bits[15:0];
        e.fl = {p < 0, p == 0, 1'b0, (p < -32768 || p > 32767)};
      end
      2'd1: begin
        dvd = longint'($signed({ih, il}));
        d   = longint'($signed(ia));
        if (d == 0) begin
          e.fl  = 4'b0011;
          e.lat = 1;
        end else begin
          q = dvd / d;
          r = dvd % d;
          if (q > 32767 || q < -32768) e.fl = 4'b0010;
          else begin
            bits = q; e.rh = bits[15:0];
            bits = r; e.rl = bits[15:0];
            e.fl = {q < 0, q == 0, 2'b00};
          end
        end
      end
      default: begin
        n   = $signed(ia[5:0]);
        mag = (n < 0) ? -n : n;
        nb  = (o == 2'd3) ? 32 : 16;
        x   = (o == 2'd3) ? longint'($signed({ih, il})) : longint'($signed(il));
        c = 1'b0; v = 1'b0;
        for (int k = 0; k < mag; k++) begin
          if (n > 0) begin
            c  = (x < 0);
            nx = wrap(x * 2, nb);
            if ((nx < 0) != (x < 0)) v = 1'b1;
            x = nx;
          end else begin
            c = ((x & 1) != 0);
            x = x >>> 1;
          end
        end
        bits = x;
        if (o == 2'd3) begin
          e.rh = bits[31:16];
          e.rl = bits[15:0];
        end else begin
          e.rl = bits[15:0];
        end
        e.fl  = {x < 0, x == 0, v, c};
        e.lat = mag + 1;
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("done_without_request", done, 1'b0);
      else begin
        m = sb.pop_front();
        chk("res_hi", res_hi, m.rh);
        chk("res_lo", res_lo, m.rl);
        chk("flags", flags, m.fl);
        chk("done_cycle", cyc, m.at);
        chk("busy_in_done", busy, 1'b0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] ia, ih, il,
                       input bit now, input bit accept);
    exp_t e;
    if (!now) @(negedge clk);
    op = o; a = ia; hi = ih; lo = il; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = 16'($urandom); hi = 16'($urandom); lo = 16'($urandom);
    if (accept) begin
      e    = model(o, ia, ih, il);
      e.at = cyc + e.lat;
      sb.push_back(e);
    end
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) chk("done_timeout", done, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra, rh, rl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_res_hi", res_hi, 16'h0);
    chk("rst_res_lo", res_lo, 16'h0);
    chk("rst_flags", flags, 4'h0);

    issue(EIS_MUL,  16'hFFFD, 16'h0000, 16'h0007, 0, 1); wait_done();
    issue(EIS_MUL,  16'h0100, 16'h0000, 16'h0100, 0, 1); wait_done();
    issue(EIS_DIV,  16'hFFF9, 16'h0000, 16'h0064, 0, 1); wait_done();
    issue(EIS_DIV,  16'h0000, 16'h1234, 16'h5678, 0, 1); wait_done();
    issue(EIS_DIV,  16'h0001, 16'h0001, 16'h0000, 0, 1); wait_done();
    issue(EIS_DIV,  16'hFFFF, 16'h8000, 16'h0000, 0, 1); wait_done();
    issue(EIS_ASHC, 16'h0001, 16'h4000, 16'h0001, 0, 1); wait_done();
    issue(EIS_ASHC, 16'h003F, 16'h0000, 16'h0003, 0, 1); wait_done();
    issue(EIS_ASH,  16'h0040, 16'hABCD, 16'h0000, 0, 1); wait_done();
    issue(EIS_ASH,  16'h0020, 16'h0000, 16'h8001, 0, 1); wait_done();

    // start while busy is ignored
    issue(EIS_MUL, 16'h1234, 16'h0000, 16'hFEDC, 0, 1);
    repeat (3) @(negedge clk);
    issue(EIS_DIV, 16'h0000, 16'h1111, 16'h2222, 0, 0);
    wait_done();

    // back-to-back starts in the DONE cycle
    issue(EIS_ASH,  16'h0005, 16'h0F0F, 16'h1234, 1, 1); wait_done();
    issue(EIS_DIV,  16'h0000, 16'hCAFE, 16'hBEEF, 1, 1); wait_done();
    issue(EIS_MUL,  16'h8000, 16'h0000, 16'h8000, 1, 1); wait_done();

    // reset at MUL edge 5 aborts without a done pulse
    issue(EIS_MUL, 16'h0003, 16'h0000, 16'h0005, 0, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_res_hi", res_hi, 16'h0);
    chk("abort_res_lo", res_lo, 16'h0);
    chk("abort_flags", flags, 4'h0);
    repeat (25) @(negedge clk);
    issue(EIS_MUL, 16'hFF00, 16'h0000, 16'h0123, 0, 1); wait_done();

    for (int i = 0; i < 200; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rh = 16'($urandom);
      rl = 16'($urandom);
      if (ro == 2'd1) begin
        if ($urandom_range(0, 1) == 1) rh = {16{rl[15]}};
        if ($urandom_range(0, 15) == 0) ra = 16'h0000;
      end
      issue(ro, ra, rh, rl, bit'($urandom_range(0, 1)), 1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
